// File: rtl/gnn_pkg.sv
// rtl/gnn_pkg.sv - shared constants and state type for the GNN layer stages
package gnn_pkg;

    localparam int SCORE_W     = 21;
    localparam int NUM_CLASSES = 4;
    localparam int NODE_W      = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/gnn_argmax_out_if.sv
// rtl/gnn_argmax_out_if.sv - score stream in, argmax result out
interface gnn_argmax_out_if #(
    parameter int SCORE_W     = gnn_pkg::SCORE_W,
    parameter int NUM_CLASSES = gnn_pkg::NUM_CLASSES,
    parameter int NODE_W      = gnn_pkg::NODE_W
);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic signed [SCORE_W-1:0] score_in;
    logic                      score_valid;
    logic                      score_last;
    logic                      score_ready;
    logic [IDX_W-1:0]          cls_out;
    logic signed [SCORE_W-1:0] max_out;
    logic [NODE_W-1:0]         node_id;
    logic                      len_err;
    logic                      out_valid;
    logic                      out_ready;

    // master is the environment (score producer plus result sink), slave is the block
    modport master (
        output score_in, score_valid, score_last, out_ready,
        input  score_ready, cls_out, max_out, node_id, len_err, out_valid
    );

    modport slave (
        input  score_in, score_valid, score_last, out_ready,
        output score_ready, cls_out, max_out, node_id, len_err, out_valid
    );

endinterface

// File: rtl/gnn_argmax_out.sv
// rtl/gnn_argmax_out.sv - per-node running argmax over layer-2 class scores
module gnn_argmax_out
    import gnn_pkg::*;
#(
    parameter int SCORE_W     = gnn_pkg::SCORE_W,
    parameter int NUM_CLASSES = gnn_pkg::NUM_CLASSES,
    parameter int NODE_W      = gnn_pkg::NODE_W
) (
    input logic         clk,
    input logic         rst_n,
    gnn_argmax_out_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, run_idx_q, win_idx;
    logic signed [SCORE_W-1:0] run_max_q, win_max;
    logic                      accept, cnt_full, node_end, take;
    logic                      handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (node_end)  state_d = HOLD;
            HOLD:    if (handshake) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Winner including the current beat; the first beat of a node always wins
    always_comb begin
        accept    = bus.score_valid && bus.score_ready && (state_q == ACCUM);
        cnt_full  = (cnt_q == IDX_W'(NUM_CLASSES - 1));
        node_end  = accept && (bus.score_last || cnt_full);
        handshake = (state_q == HOLD) && bus.out_valid && bus.out_ready;
        take      = (cnt_q == '0) || (bus.score_in > run_max_q);
        win_max   = take ? bus.score_in : run_max_q;
        win_idx   = take ? cnt_q : run_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            run_idx_q       <= '0;
            run_max_q       <= '0;
            bus.score_ready <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.cls_out     <= '0;
            bus.max_out     <= '0;
            bus.node_id     <= '0;
            bus.len_err     <= 1'b0;
        end else begin
            if (accept) begin
                run_max_q <= win_max;
                run_idx_q <= win_idx;
                cnt_q     <= node_end ? '0 : cnt_q + 1'b1;
            end
            if (node_end) begin
                bus.cls_out     <= win_idx;
                bus.max_out     <= win_max;
                bus.len_err     <= (bus.score_last != cnt_full);
                bus.out_valid   <= 1'b1;
                bus.score_ready <= 1'b0;
            end else if (state_q == ACCUM) begin
                bus.score_ready <= 1'b1;
            end
            if (handshake) begin
                bus.out_valid   <= 1'b0;
                bus.score_ready <= 1'b1;
                bus.node_id     <= bus.node_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gnn_argmax_out.sv
// tb/tb_gnn_argmax_out.sv - self-checking bench for gnn_argmax_out
module tb_gnn_argmax_out;
    import gnn_pkg::*;

    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gnn_argmax_out_if #(.SCORE_W(SCORE_W), .NUM_CLASSES(NUM_CLASSES), .NODE_W(NODE_W)) bus();

    gnn_argmax_out #(.SCORE_W(SCORE_W), .NUM_CLASSES(NUM_CLASSES), .NODE_W(NODE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [SCORE_W-1:0] vals[$];
    int                        last_pos;
    logic [NODE_W-1:0]         exp_node;

    logic                      obs_valid;
    logic [IDX_W-1:0]          obs_cls;
    logic signed [SCORE_W-1:0] obs_max;
    logic [NODE_W-1:0]         obs_node;
    logic                      obs_err;

    task automatic load4(input int a, input int b, input int c, input int d, input int n, input int lp);
        int t[4];
        t = '{a, b, c, d};
        vals.delete();
        for (int i = 0; i < n; i++) vals.push_back(SCORE_W'(t[i]));
        last_pos = lp;
    endtask

    // Reference: argmax over the node's accepted scores, strict > so ties keep the lower class
    function automatic void model(output logic [IDX_W-1:0] c, output logic signed [SCORE_W-1:0] m,
                                  output logic e);
        m = vals[0];
        c = '0;
        for (int i = 1; i < vals.size(); i++)
            if (vals[i] > m) begin
                m = vals[i];
                c = IDX_W'(i);
            end
        e = ((last_pos == vals.size() - 1) != (vals.size() == NUM_CLASSES));
    endfunction

    task automatic feed_node();
        for (int i = 0; i < vals.size(); i++) begin
            logic acc;
            int   guard;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 64) begin
                @(negedge clk);
                bus.out_ready   = 1'b0;
                bus.score_valid = 1'b1;
                bus.score_in    = vals[i];
                bus.score_last  = (i == last_pos);
                acc             = bus.score_ready;
                guard++;
                @(posedge clk);
            end
            if (!acc) begin
                n_tests++; n_fail++;
                $display("FAIL feed_timeout beat %0d: score_ready got 0 required 1", i);
            end
        end
        @(negedge clk);
        bus.score_valid = 1'b0;
        bus.score_last  = 1'b0;
        obs_valid = bus.out_valid;
        obs_cls   = bus.cls_out;
        obs_max   = bus.max_out;
        obs_node  = bus.node_id;
        obs_err   = bus.len_err;
    endtask

    task automatic release_result(input int stall);
        repeat (stall) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        exp_node = exp_node + 1'b1;
    endtask

    task automatic test_reset();
        bus.score_in = '0; bus.score_valid = 1'b0; bus.score_last = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.score_ready, bus.out_valid, bus.cls_out, bus.max_out, bus.node_id, bus.len_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b cls=%0d max=%0d node=%0d err=%0b required all 0",
                     bus.score_ready, bus.out_valid, bus.cls_out, bus.max_out, bus.node_id, bus.len_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.score_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_rise: got %0b required 1", bus.score_ready);
        end
        exp_node = '0;
    endtask

    task automatic test_argmax();
        int tab[3][4] = '{'{100, -50, 300, 7}, '{5, 9, 9, -1}, '{-1048576, -3, -3, -200}};
        int ec[3] = '{2, 1, 1};
        int em[3] = '{300, 9, -3};
        for (int t = 0; t < 3; t++) begin
            load4(tab[t][0], tab[t][1], tab[t][2], tab[t][3], 4, 3);
            feed_node();
            n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL argmax_valid n%0d: got %0b required 1", t, obs_valid); end
            n_tests++; if (obs_cls !== IDX_W'(ec[t])) begin n_fail++; $display("FAIL argmax_cls n%0d: got %0d required %0d", t, obs_cls, ec[t]); end
            n_tests++; if (obs_max !== SCORE_W'(em[t])) begin n_fail++; $display("FAIL argmax_max n%0d: got %0d required %0d", t, obs_max, em[t]); end
            n_tests++; if (obs_node !== exp_node) begin n_fail++; $display("FAIL argmax_node n%0d: got %0d required %0d", t, obs_node, exp_node); end
            n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL argmax_err n%0d: got %0b required 0", t, obs_err); end
            release_result(t);
        end
    endtask

    task automatic test_backpressure();
        logic [NODE_W-1:0] held_node;
        load4(8, 8, -8, 2, 4, 3);
        feed_node();
        held_node = exp_node;
        for (int k = 0; k < 5; k++) begin
            bus.score_valid = 1'b1;
            bus.score_in    = SCORE_W'($urandom);
            @(negedge clk);
            n_tests++;
            if ({bus.out_valid, bus.score_ready} !== 2'b10) begin
                n_fail++; $display("FAIL hold_handshake c%0d: got vld=%0b rdy=%0b required vld=1 rdy=0", k, bus.out_valid, bus.score_ready);
            end
            n_tests++;
            if ({bus.cls_out, bus.max_out, bus.node_id, bus.len_err} !== {IDX_W'(0), SCORE_W'(8), held_node, 1'b0}) begin
                n_fail++; $display("FAIL hold_stable c%0d: got cls=%0d max=%0d node=%0d err=%0b required cls=0 max=8 node=%0d err=0",
                                   k, bus.cls_out, bus.max_out, bus.node_id, bus.len_err, held_node);
            end
        end
        release_result(0);
        load4(11, -4, 12, 12, 4, 3);
        feed_node();
        n_tests++; if (obs_node !== held_node + 1'b1) begin n_fail++; $display("FAIL bp_next_node: got %0d required %0d", obs_node, held_node + 1'b1); end
        n_tests++; if ({obs_cls, obs_max} !== {IDX_W'(2), SCORE_W'(12)}) begin n_fail++; $display("FAIL bp_next_result: got cls=%0d max=%0d required cls=2 max=12", obs_cls, obs_max); end
        release_result(1);
    endtask

    task automatic test_len_err();
        load4(10, 20, 0, 0, 2, 1);
        feed_node();
        n_tests++;
        if ({obs_valid, obs_cls, obs_max, obs_err} !== {1'b1, IDX_W'(1), SCORE_W'(20), 1'b1}) begin
            n_fail++; $display("FAIL len_short: got vld=%0b cls=%0d max=%0d err=%0b required vld=1 cls=1 max=20 err=1", obs_valid, obs_cls, obs_max, obs_err);
        end
        release_result(0);
        load4(1, 2, 3, 4, 4, -1);
        feed_node();
        n_tests++;
        if ({obs_valid, obs_cls, obs_max, obs_err} !== {1'b1, IDX_W'(3), SCORE_W'(4), 1'b1}) begin
            n_fail++; $display("FAIL len_nolast: got vld=%0b cls=%0d max=%0d err=%0b required vld=1 cls=3 max=4 err=1", obs_valid, obs_cls, obs_max, obs_err);
        end
        release_result(0);
    endtask

    task automatic test_reset_mid();
        load4(50, 60, 0, 0, 2, -1);
        feed_node();
        n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL partial_valid: got %0b required 0", obs_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.score_ready, bus.out_valid, bus.cls_out, bus.max_out, bus.node_id, bus.len_err} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got rdy=%0b vld=%0b cls=%0d max=%0d node=%0d err=%0b required all 0",
                               bus.score_ready, bus.out_valid, bus.cls_out, bus.max_out, bus.node_id, bus.len_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_node = '0;
        load4(3, 1, 1, 1, 4, 3);
        feed_node();
        n_tests++;
        if ({obs_valid, obs_cls, obs_max, obs_node, obs_err} !== {1'b1, IDX_W'(0), SCORE_W'(3), NODE_W'(0), 1'b0}) begin
            n_fail++; $display("FAIL after_reset: got vld=%0b cls=%0d max=%0d node=%0d err=%0b required vld=1 cls=0 max=3 node=0 err=0",
                               obs_valid, obs_cls, obs_max, obs_node, obs_err);
        end
        release_result(0);
    endtask

    task automatic test_random_wrap();
        logic [IDX_W-1:0]          ec;
        logic signed [SCORE_W-1:0] em;
        logic                      ee;
        for (int n = 0; n < 256; n++) begin
            int len;
            len = $urandom_range(1, NUM_CLASSES);
            vals.delete();
            for (int i = 0; i < len; i++) begin
                int v;
                v = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) - 2 : int'($urandom);
                vals.push_back(SCORE_W'(v));
            end
            last_pos = (len < NUM_CLASSES || $urandom_range(0, 1) == 1) ? len - 1 : -1;
            model(ec, em, ee);
            feed_node();
            n_tests++;
            if ({obs_valid, obs_cls, obs_max, obs_node, obs_err} !== {1'b1, ec, em, exp_node, ee}) begin
                n_fail++; $display("FAIL rand n%0d: got vld=%0b cls=%0d max=%0d node=%0d err=%0b required vld=1 cls=%0d max=%0d node=%0d err=%0b",
                                   n, obs_valid, obs_cls, obs_max, obs_node, obs_err, ec, em, exp_node, ee);
            end
            release_result($urandom_range(0, 2));
        end
        n_tests++;
        if (exp_node !== NODE_W'(1)) begin
            n_fail++; $display("FAIL wrap_count: got %0d required 1", exp_node);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_argmax();
        test_backpressure();
        test_len_err();
        test_reset_mid();
        test_random_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
